sprite_loader: RTL and testbench

SPRITE_LOADER -- requirements
Module: sprite_loader

---
 rtl/sprite_loader.sv | 137 +++++++++++++
 tb/tb_sprite_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_loader.sv
// Sprite loader: receives bytes of four packed colour codes from a
// valid/ready source, unpacks each byte into four single-pixel writes and
// streams them into one slot of the sprite RAM. A sprite is SPRITE_PIXELS
// pixels; after the final write a one-cycle done pulse is issued. A load can
// be cancelled with abort, which produces a one-cycle aborted pulse instead.
module sprite_loader #(
  parameter int PIXEL_BITS     = 2,
  parameter int SPRITE_PIXELS  = 64,
  parameter int PIX_ADDR_WIDTH = 6,
  parameter int SLOT_BITS      = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [SLOT_BITS-1:0]                slot,
  input  logic                                abort,
  input  logic                                in_valid,
  input  logic [7:0]                          in_data,
  output logic                                in_ready,
  output logic                                wr_en,
  output logic [SLOT_BITS+PIX_ADDR_WIDTH-1:0] wr_addr,
  output logic [PIXEL_BITS-1:0]               wr_data,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted
);

  // Pixels carried by one source byte and the width of the in-byte counter.
  localparam int PIX_PER_BYTE = 8 / PIXEL_BITS;
  localparam int SUB_W        = (PIX_PER_BYTE > 1) ? $clog2(PIX_PER_BYTE) : 1;

  localparam logic [SUB_W-1:0]          SUB_LAST = SUB_W'(PIX_PER_BYTE - 1);
  localparam logic [PIX_ADDR_WIDTH-1:0] PIX_LAST = PIX_ADDR_WIDTH'(SPRITE_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    UNPACK    = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [SLOT_BITS-1:0]        slot_q, slot_d;
  logic [PIX_ADDR_WIDTH-1:0]   pixel_q, pixel_d;
  logic [SUB_W-1:0]            sub_q, sub_d;
  logic [7:0]                  shift_q, shift_d;

  // State and datapath registers; reset clears everything asynchronously so
  // a mid-load reset cancels silently and leaves the block idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      pixel_q <= '0;
      sub_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pixel_q <= pixel_d;
      sub_q   <= sub_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic plus the handshake/strobe outputs. abort is honoured
  // only while a load is in flight and masks in_ready/wr_en in that cycle.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    pixel_d  = pixel_q;
    sub_d    = sub_q;
    shift_d  = shift_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    aborted  = 1'b0;

    case (state_q)
      IDLE: begin
        // start beats a simultaneous abort simply because abort is not
        // looked at while idle.
        if (start) begin
          slot_d  = slot;
          pixel_d = '0;
          state_d = WAIT_BYTE;
        end
      end

      WAIT_BYTE: begin
        in_ready = ~abort;
        if (abort) begin
          aborted = 1'b1;
          state_d = IDLE;
        end else if (in_valid) begin
          shift_d = in_data;
          sub_d   = '0;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        if (abort) begin
          aborted = 1'b1;
          state_d = IDLE;
        end else begin
          wr_en   = 1'b1;
          shift_d = shift_q >> PIXEL_BITS;
          pixel_d = pixel_q + PIX_ADDR_WIDTH'(1);
          sub_d   = sub_q + SUB_W'(1);
          if (sub_q == SUB_LAST) begin
            if (pixel_q == PIX_LAST) begin
              // Explicit wrap keeps non-power-of-two sprite sizes correct.
              pixel_d = '0;
              state_d = DONE;
            end else begin
              state_d = WAIT_BYTE;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_addr = {slot_q, pixel_q};
  assign wr_data = shift_q[PIXEL_BITS-1:0];
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_sprite_loader.sv
// Testbench for sprite_loader: directed scenarios followed by a random soak,
// every cycle compared against a transaction-level model that tracks the
// pending pixels of the current byte in a queue.
module tb_sprite_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] slot;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [1:0] wr_data;
  logic       busy;
  logic       done;
  logic       aborted;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr     = 0;
  int n_done   = 0;
  int n_ab     = 0;

  // Reference model: a load is either running or not; pixels of the byte
  // being unpacked wait in a queue; m_pix counts pixels already written.
  bit m_busy = 0;
  bit m_done = 0;
  int m_slot = 0;
  int m_pix  = 0;
  int pend[$];

  sprite_loader #(
    .PIXEL_BITS    (2),
    .SPRITE_PIXELS (64),
    .PIX_ADDR_WIDTH(6),
    .SLOT_BITS     (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .slot    (slot),
    .abort   (abort),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_done = 0;
    m_pix  = 0;
    pend.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the model, then advance the model to the following rising edge.
  task automatic step(input bit st, input logic [2:0] sl, input bit ab,
                      input bit iv, input logic [7:0] d);
    bit e_ready, e_wr, e_ab;
    @(negedge clk);
    start    = st;
    slot     = sl;
    abort    = ab;
    in_valid = iv;
    in_data  = d;
    #2;
    e_ready = m_busy && !m_done && (pend.size() == 0) && !ab;
    e_wr    = m_busy && (pend.size() > 0) && !ab;
    e_ab    = m_busy && !m_done && ab;
    chk("in_ready", int'(in_ready), int'(e_ready));
    chk("wr_en",    int'(wr_en),    int'(e_wr));
    chk("busy",     int'(busy),     int'(m_busy));
    chk("done",     int'(done),     int'(m_done));
    chk("aborted",  int'(aborted),  int'(e_ab));
    if (e_wr) begin
      chk("wr_addr", int'(wr_addr), m_slot * 64 + m_pix);
      chk("wr_data", int'(wr_data), pend[0]);
    end
    if (wr_en)   n_wr++;
    if (done)    n_done++;
    if (aborted) n_ab++;

    if (!m_busy) begin
      if (st) begin
        m_busy = 1;
        m_slot = int'(sl);
        m_pix  = 0;
        pend.delete();
      end
    end else if (m_done) begin
      m_busy = 0;
      m_done = 0;
    end else if (ab) begin
      m_busy = 0;
      pend.delete();
    end else if (pend.size() > 0) begin
      void'(pend.pop_front());
      m_pix++;
      if (pend.size() == 0 && m_pix == 64) m_done = 1;
    end else if (iv) begin
      for (int j = 0; j < 4; j++) pend.push_back((int'(d) >> (2 * j)) & 3);
    end
  endtask

  // Complete load with in_valid held high; optional abort alongside start and
  // during the done cycle (both must be ignored).
  task automatic run_load(input logic [2:0] sl, input bit st_ab, input bit ab_done,
                          input bit rnd, input logic [7:0] fixed);
    step(1'b1, sl, st_ab, 1'b0, 8'h00);
    for (int c = 0; c < 200 && m_busy; c++)
      step(1'b0, 3'd0, ab_done && m_done, 1'b1, rnd ? 8'($urandom) : fixed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; slot = 3'd0; abort = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    #3;
    chk("rst_wr_en",    int'(wr_en),    0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_done",     int'(done),     0);
    chk("rst_aborted",  int'(aborted),  0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Full load of slot 3 with 0xE4: addresses 192..255, data 0,1,2,3.
    n_wr = 0; n_done = 0;
    run_load(3'd3, 1'b0, 1'b0, 1'b0, 8'hE4);
    chk("full_writes", n_wr, 64);
    chk("full_done",   n_done, 1);

    // Byte 0x1B into slot 0 (writes 3,2,1,0); start+abort in idle, abort in done.
    n_done = 0; n_ab = 0;
    run_load(3'd0, 1'b1, 1'b1, 1'b0, 8'h1B);
    chk("startab_done", n_done, 1);
    chk("startab_ab",   n_ab, 0);

    // Stall of 10 cycles between bytes 5 and 6 of a slot-1 load.
    step(1'b1, 3'd1, 1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 16; b++) begin
      if (b == 6) repeat (10) step(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 3'd0, 1'b0, 1'b1, 8'($urandom));
      repeat (4) step(1'b0, 3'd0, 1'b0, 1'b1, 8'($urandom));
    end
    step(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);

    // Abort after the 2nd pixel of byte 2, then reload slot 0.
    n_done = 0; n_ab = 0;
    step(1'b1, 3'd4, 1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 2; b++) begin
      step(1'b0, 3'd0, 1'b0, 1'b1, 8'($urandom));
      repeat (4) step(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    end
    step(1'b0, 3'd0, 1'b0, 1'b1, 8'h6C);
    step(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    chk("abort_pulses", n_ab, 1);
    chk("abort_done",   n_done, 0);
    run_load(3'd0, 1'b0, 1'b0, 1'b1, 8'h00);

    // start with slot 5 while loading slot 2 must be ignored.
    n_wr = 0;
    step(1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 200 && m_busy; c++)
      step((c % 7) == 3, 3'd5, 1'b0, 1'b1, 8'($urandom));
    chk("ignore_writes", n_wr, 64);

    // Asynchronous reset in the middle of unpacking.
    step(1'b1, 3'd6, 1'b0, 1'b0, 8'h00);
    step(1'b0, 3'd0, 1'b0, 1'b1, 8'hA5);
    step(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en",    int'(wr_en),    0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_busy",     int'(busy),     0);
    chk("mid_rst_done",     int'(done),     0);
    chk("mid_rst_aborted",  int'(aborted),  0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 3'd0, 1'b0, 1'b1, 8'h00);

    // Random soak.
    for (int c = 0; c < 3000; c++)
      step(($urandom % 10) == 0, 3'($urandom), ($urandom % 50) == 0,
           ($urandom % 4) != 0, 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
